// File: rtl/spi_frame_master.sv
// SPI frame initiator: serialises 10-bit command words into SS_n-framed
// transactions and returns the slave's byte for read-data commands.
module spi_frame_master #(
  parameter int TURN = 2,
  parameter int GAP  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [9:0] cmd_data,
  output logic       cmd_ready,
  output logic       MOSI,
  output logic       SS_n,
  input  logic       MISO,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHK   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TURN  = 3'd3,
    ST_RECV  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  localparam logic [3:0] TURN_LAST  = 4'(TURN - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP - 1);
  localparam logic [3:0] SHIFT_LAST = 4'd9;
  localparam logic [3:0] RECV_LAST  = 4'd7;

  state_t     state_reg;
  state_t     state_next;
  logic [3:0] cnt_reg;
  logic [9:0] sh_reg;
  logic       is_rd_reg;
  logic [6:0] rx_reg;
  logic [7:0] rd_data_reg;
  logic       rd_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (cmd_valid) state_next = ST_CHK;
      ST_CHK:   state_next = ST_SHIFT;
      ST_SHIFT: if (cnt_reg == SHIFT_LAST) state_next = is_rd_reg ? ST_TURN : ST_GAP;
      ST_TURN:  if (cnt_reg == TURN_LAST) state_next = ST_RECV;
      ST_RECV:  if (cnt_reg == RECV_LAST) state_next = ST_GAP;
      ST_GAP:   if (cnt_reg == GAP_LAST) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // One shared phase counter, cleared on every state change and saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= 4'd0;
      sh_reg       <= 10'd0;
      is_rd_reg    <= 1'b0;
      rx_reg       <= 7'd0;
      rd_data_reg  <= 8'd0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= 1'b0;
      if (state_next != state_reg) begin
        cnt_reg <= 4'd0;
      end else if (cnt_reg != 4'hf) begin
        cnt_reg <= cnt_reg + 4'd1;
      end
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            sh_reg    <= cmd_data;
            is_rd_reg <= (cmd_data[9:8] == 2'b11);
          end
        end
        ST_SHIFT: sh_reg <= {sh_reg[8:0], 1'b0};
        ST_RECV: begin
          rx_reg <= {rx_reg[5:0], MISO};
          if (cnt_reg == RECV_LAST) begin
            rd_data_reg  <= {rx_reg, MISO};
            rd_valid_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // CHK repeats the top command bit so the slave can sample its select bit.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    SS_n      = 1'b1;
    MOSI      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_CHK, ST_SHIFT: begin
        SS_n = 1'b0;
        MOSI = sh_reg[9];
      end
      ST_TURN, ST_RECV: SS_n = 1'b0;
      default: ;
    endcase
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_spi_frame_master.sv
// Randomised scoreboard bench for spi_frame_master with a behavioural
// SPI slave + RAM peer and a command-level reference model.
module tb_spi_frame_master;
  localparam int TURN = 2;
  localparam int GAP  = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [9:0] cmd_data = 10'd0;
  logic       cmd_ready;
  logic       MOSI;
  logic       SS_n;
  logic       MISO = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;

  int total = 0;
  int bad = 0;

  spi_frame_master #(.TURN(TURN), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .MOSI(MOSI), .SS_n(SS_n), .MISO(MISO),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [31:0] bits;
    logic [9:0]  cmd;
  } frame_t;

  frame_t     frame_q[$];
  logic [7:0] rd_q[$];

  // Command-level reference model of the slave's address/RAM behaviour.
  logic [7:0] r_ram [256];
  logic [7:0] r_waddr = 8'd0;
  logic [7:0] r_raddr = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_cmd(input logic [9:0] c);
    frame_t f;
    f.cmd  = c;
    f.len  = 11 + ((c[9:8] == 2'b11) ? TURN + 8 : 0);
    f.bits = 32'd0;
    f.bits[0] = c[9];
    for (int i = 0; i < 10; i++) f.bits[1 + i] = c[9 - i];
    frame_q.push_back(f);
    case (c[9:8])
      2'b00: r_waddr = c[7:0];
      2'b01: r_ram[r_waddr] = c[7:0];
      2'b10: r_raddr = c[7:0];
      default: rd_q.push_back(r_ram[r_raddr]);
    endcase
  endtask

  // Present c; while the master is busy the data lines carry junk.
  task automatic send(input logic [9:0] c);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 300) begin
      cmd_data = 10'($urandom);
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: cmd_ready=0, required 1");
      cmd_valid = 1'b0;
      return;
    end
    cmd_data = c;
    expect_cmd(c);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data = 10'($urandom);
  endtask

  // Behavioural slave: samples MOSI mid-cycle, answers read-data on MISO.
  logic [7:0] s_ram [256];
  logic [7:0] s_waddr = 8'd0;
  logic [7:0] s_raddr = 8'd0;
  logic [7:0] s_tx = 8'd0;
  logic [9:0] s_sh = 10'd0;
  int         s_c = 0;

  always @(negedge clk) begin
    if (!rst_n || SS_n) begin
      s_c  = 0;
      MISO = 1'($urandom);
    end else begin
      if (s_c >= 1 && s_c <= 10) s_sh = {s_sh[8:0], MOSI};
      if (s_c == 10) begin
        case (s_sh[9:8])
          2'b00: s_waddr = s_sh[7:0];
          2'b01: s_ram[s_waddr] = s_sh[7:0];
          2'b10: s_raddr = s_sh[7:0];
          default: s_tx = s_ram[s_raddr];
        endcase
      end
      if (s_c >= 11 + TURN && s_c <= 18 + TURN) MISO = s_tx[7 - (s_c - 11 - TURN)];
      else MISO = 1'($urandom);
      s_c++;
    end
  end

  // Monitor: frame shape, handshake timing and read results.
  int          low_cnt = 0;
  int          since_rise = 100;
  int          frame_no = 0;
  logic [31:0] bits = 32'd0;
  logic        prev_ss = 1'b1;
  logic        exp_ready;

  always @(negedge clk) begin
    if (!rst_n) begin
      frame_q.delete();
      rd_q.delete();
      low_cnt = 0;
      bits = 32'd0;
      prev_ss = 1'b1;
      since_rise = 100;
    end else begin
      exp_ready = SS_n && (since_rise >= GAP);
      check("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
      check("busy", 32'(busy), 32'(!exp_ready));
      if (SS_n) check("mosi_idle_zero", 32'(MOSI), 32'd0);
      if (rd_valid) begin
        check("rd_valid_at_ss_rise", 32'(!prev_ss && SS_n), 32'd1);
        if (rd_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_unexpected: rd_valid=1 with rd_data=0x%0h, required no strobe", rd_data);
        end else begin
          logic [7:0] e;
          e = rd_q.pop_front();
          check("rd_data", 32'(rd_data), 32'(e));
          $display("read result: rd_data=0x%02h expected=0x%02h", rd_data, e);
        end
      end
      if (!SS_n) begin
        if (prev_ss) check("gap_min", 32'(since_rise >= GAP + 1), 32'd1);
        if (low_cnt < 32) bits[low_cnt] = MOSI;
        low_cnt++;
        since_rise = 0;
      end else begin
        if (!prev_ss) begin
          if (frame_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL frame_unexpected: len=%0d, required no frame", low_cnt);
          end else begin
            frame_t f;
            f = frame_q.pop_front();
            check("frame_len", 32'(low_cnt), 32'(f.len));
            check("frame_mosi", bits, f.bits);
            $display("frame %0d: cmd=0x%03h len=%0d mosi=0x%06h", frame_no, f.cmd, low_cnt, bits);
          end
          frame_no++;
          low_cnt = 0;
          bits = 32'd0;
        end
        if (since_rise < 100) since_rise++;
      end
      prev_ss = SS_n;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0] op;
    foreach (r_ram[i]) r_ram[i] = 8'd0;
    foreach (s_ram[i]) s_ram[i] = 8'd0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_ss_n", 32'(SS_n), 32'd1);
    check("reset_mosi", 32'(MOSI), 32'd0);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Abort a frame mid-SHIFT with an asynchronous reset.
    send(10'h0AB);
    repeat (4) @(posedge clk);
    #2;
    check("ss_low_before_reset", 32'(SS_n), 32'd0);
    rst_n = 1'b0;
    #1;
    check("async_reset_ss_n", 32'(SS_n), 32'd1);
    check("async_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("async_reset_rd_valid", 32'(rd_valid), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    send(10'h0A5);
    send(10'h1C3);
    send(10'h2C3);
    send(10'h020);
    send(10'h15A);
    send(10'h220);
    send(10'h300);
    send(10'h010);
    send(10'h13C);
    send(10'h210);
    send(10'h300);

    for (int k = 0; k < 80; k++) begin
      op = 2'($urandom_range(0, 3));
      if (op == 2'b01 || op == 2'b11) send({op, 8'($urandom)});
      else send({op, 8'($urandom_range(0, 7))});
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    n = 0;
    while ((frame_q.size() != 0 || rd_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("frame_q_drained", 32'(frame_q.size()), 32'd0);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_frame_master.md
Name: spi_frame_master

Overview:
- SPI initiator that drives the team's SPI slave + single-port RAM subsystem over MOSI/SS_n/MISO, sharing its system clock.
- Accepts 10-bit command words from a host-side valid/ready interface and serialises each into one SS_n-framed transaction.
- For read-data commands, captures the 8-bit byte the slave returns on MISO and presents it on a one-cycle valid strobe.
- Sits in the testbench/host-side subsystem as the peer of the slave wrapper.

Parameters:
- TURN, 2, idle cycles after the last MOSI bit of a read-data frame before the first MISO sample (slave RAM access + tx load); legal 1..15.
- GAP, 1, minimum cycles SS_n is held high between frames; legal 1..15.

Ports:
- clk  input  1  system clock; all outputs update on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  host presents a command word.
- cmd_data  input  10  command word: [9:8] = 00 write-address, 01 write-data, 10 read-address, 11 read-data; [7:0] = address/data/don't-care.
- cmd_ready  output  1  high when the master can accept a command.
- MOSI  output  1  serial data to slave.
- SS_n  output  1  active-low slave select.
- MISO  input  1  serial data from slave.
- rd_data  output  8  byte received in a read-data frame.
- rd_valid  output  1  one-cycle strobe qualifying rd_data.
- busy  output  1  high from SS_n fall until the GAP phase ends.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: SS_n=1, MOSI=0, cmd_ready=1, rd_data=0, rd_valid=0, busy=0, state=IDLE, all counters 0.
- Reset asserted mid-frame: SS_n rises immediately (async), the frame is abandoned, no rd_valid is issued.
- Handshake: a command is accepted on a clk edge with cmd_valid & cmd_ready. cmd_data is latched into a 10-bit shift register; cmd_ready drops in the same edge. cmd_ready=1 only in IDLE.
- IDLE: on accept -> CHK. SS_n=0 and MOSI=cmd_data[9] are driven from that edge.
- CHK (1 cycle): MOSI=cmd[9], the command-select bit sampled by the slave -> SHIFT.
- SHIFT (10 cycles): MOSI = cmd bits 9 down to 0, MSB first, one bit per cycle; bit counter 0..9.
  - After bit 0: cmd[9:8]=11 -> TURN; otherwise -> GAP with SS_n=1.
- TURN (TURN cycles): SS_n held 0, MOSI=0, MISO ignored -> RECV.
- RECV (8 cycles): MISO sampled on each rising edge, MSB first, into an 8-bit shift register.
  - On the edge that samples the 8th bit: rd_data updates with the full byte and rd_valid=1 for exactly one cycle.
  - SS_n=1 from that edge -> GAP.
- GAP (GAP cycles): SS_n=1, MOSI=0, busy=1 -> IDLE; cmd_ready=1 on the first IDLE cycle.
- Frame length (SS_n low):
  - Non-read-data commands: 11 cycles.
  - Read-data commands: 11+TURN+8 cycles.
- Accept-to-accept throughput: 11+GAP+1 cycles; read-data commands add TURN+8.
- MOSI is 0 whenever SS_n=1.
- cmd_valid asserted while cmd_ready=0 is ignored and has no side effects; the host holds it.
- rd_data holds its value until the next read-data frame completes.
- MISO is X-tolerant outside RECV: never sampled there.
- Counters are 4-bit and saturate by design; no wrap occurs within a legal frame.

Test Plan:
- Reset: assert rst_n=0 mid-SHIFT of cmd 0x0AB -> SS_n=1, cmd_ready=1, rd_valid=0 asynchronously; after release, the next accepted command is framed cleanly from CHK.
- Write-address: cmd 0x0A5 -> SS_n low exactly 11 cycles; MOSI sequence 0, 0,0,1,0,1,0,0,1,0,1; no rd_valid; cmd_ready returns after GAP.
- Write-data then read-address: cmds 0x1C3, then 0x2C3 held valid back-to-back -> second SS_n fall exactly GAP+1 cycles after the first SS_n rise; MOSI first bit 0 then 1 respectively.
- Read-data with slave model returning 0x5A, TURN=2 -> SS_n low 21 cycles; rd_data=0x5A with a single-cycle rd_valid on the edge SS_n rises.
- Full loop against the slave+RAM: write addr 0x10, write data 0x3C, read addr 0x10, read data -> rd_data=0x3C.
- Backpressure: cmd_valid held high with a changing cmd_data while busy -> only the word present at cmd_ready=1 is transmitted.
